// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if: APB4 completer bus bundle for apb_mem_slave.
interface apb_mem_slave_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic                PSEL;
   logic                PENABLE;
   logic                PWRITE;
   logic [ADDR_W-1:0]   PADDR;
   logic [DATA_W-1:0]   PWDATA;
   logic [DATA_W/8-1:0] PSTRB;
   logic [DATA_W-1:0]   PRDATA;
   logic                PREADY;
   logic                PSLVERR;
   modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, input PRDATA, PREADY, PSLVERR);
   modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 word-addressed memory completer with wait states, byte strobes and PSLVERR.
module apb_mem_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input logic           PCLK,
   input logic           PRESET,
   apb_mem_slave_if.slave apb
);
   localparam int NB = DATA_W / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << LSB) - 1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NB-1:0]     strb_q, strb_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic [IW-1:0]     widx;
   logic              err, ready, done;
   assign idx   = addr_q >> LSB;
   assign widx  = idx[IW-1:0];
   assign err   = ({1'b0, idx} >= DEPTH_L) || |(addr_q & AMASK);
   assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign done  = ready && apb.PSEL && apb.PENABLE;
   assign apb.PREADY  = ready;
   assign apb.PSLVERR = ready && err;
   assign apb.PRDATA  = (ready && !err && !write_q) ? mem[widx] : '0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      if (state_q == IDLE) begin
         if (apb.PSEL && !apb.PENABLE) begin
            state_d = ACCESS;
            cnt_d   = 4'(WAIT_CYCLES);
            addr_d  = apb.PADDR;
            write_d = apb.PWRITE;
            wdata_d = apb.PWDATA;
            strb_d  = apb.PSTRB;
         end
      end else if (!(apb.PSEL && apb.PENABLE) || ready) state_d = IDLE;
      else cnt_d = cnt_q - 4'd1;
   end
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end
   // Memory is deliberately left out of reset; only a clean completion writes it.
   always_ff @(posedge PCLK) begin
      if (!PRESET && done && write_q && !err)
         for (int i = 0; i < NB; i++)
            if (strb_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
   end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: three slaves (WAIT_CYCLES 0/2/3, ADDR_W=10) checked against an array memory model.
module tb_apb_mem_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic        psel [3];
   logic        penable [3];
   logic        pwrite [3];
   logic [9:0]  paddr [3];
   logic [31:0] pwdata [3];
   logic [3:0]  pstrb [3];
   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err [3];
   logic [31:0] m [3][64];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] rd;
   logic        e;
   int          w;
   logic        wb;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_mem_slave_if #(.DATA_W(32), .ADDR_W(10)) bus ();
      assign bus.PSEL    = psel[g];
      assign bus.PENABLE = penable[g];
      assign bus.PWRITE  = pwrite[g];
      assign bus.PADDR   = paddr[g];
      assign bus.PWDATA  = pwdata[g];
      assign bus.PSTRB   = pstrb[g];
      assign rdata[g]    = bus.PRDATA;
      assign ready[g]    = bus.PREADY;
      assign err[g]      = bus.PSLVERR;
      apb_mem_slave #(.DATA_W(32), .ADDR_W(10), .DEPTH(64), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
         .PCLK(clk), .PRESET(rst), .apb(bus));
   end
   function automatic logic exp_err(input logic [9:0] a);
      return (a[9:2] >= 8'd64) || (a[1:0] != 2'b00);
   endfunction
   task automatic mwrite(input int d, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] s);
      if (!exp_err(a))
         for (int i = 0; i < 4; i++) if (s[i]) m[d][a[7:2]][8*i +: 8] = wd[8*i +: 8];
   endtask
   task automatic xfer(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd, input logic [3:0] s,
                       output logic [31:0] r, output logic er, output int waits, output logic wbad);
      @(posedge clk); #1;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = s;
      @(posedge clk); #1;
      penable[d] = 1'b1; paddr[d] = 10'($urandom); pwdata[d] = $urandom; pstrb[d] = 4'($urandom);
      waits = 0; wbad = 1'b0;
      @(negedge clk);
      while (ready[d] !== 1'b1 && waits < 20) begin
         if (rdata[d] !== 32'h0 || err[d] !== 1'b0) wbad = 1'b1;
         waits++;
         @(negedge clk);
      end
      r = rdata[d]; er = err[d];
      if (!wr) mwrite(d, 10'h3FF, 0, 0);
      else mwrite(d, a, wd, s);
   endtask
   task automatic idle(input int d);
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 10'h10; pwdata[d] = 0; pstrb[d] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if ({ready[d], err[d], rdata[d]} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs dut%0d ready=%b err=%b rdata=%h want all 0", d, ready[d], err[d], rdata[d]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin psel[d] = 1'b0; penable[d] = 1'b0; end
   endtask
   task automatic test_basic();
      xfer(0, 1'b1, 10'h10, 32'hDEADBEEF, 4'hF, rd, e, w, wb);
      vectors++; if (w !== 0 || e !== 1'b0) begin miscompares++; $display("FAIL basic_write waits=%0d err=%b want 0/0", w, e); end
      xfer(0, 1'b0, 10'h10, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (w !== 0 || e !== 1'b0) begin miscompares++; $display("FAIL basic_read_resp waits=%0d err=%b want 0/0", w, e); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_read_data got %h want deadbeef", rd); end
   endtask
   task automatic test_wait();
      xfer(2, 1'b1, 10'h10, 32'hDEADBEEF, 4'hF, rd, e, w, wb);
      idle(2);
      vectors++; if (w !== 3) begin miscompares++; $display("FAIL wait_write waits=%0d want 3", w); end
      xfer(2, 1'b0, 10'h10, 32'h0, 4'h0, rd, e, w, wb);
      idle(2);
      vectors++; if (w !== 3) begin miscompares++; $display("FAIL wait_read waits=%0d want 3", w); end
      vectors++; if (wb !== 1'b0) begin miscompares++; $display("FAIL wait_outputs nonzero rdata/err while PREADY low"); end
      vectors++; if (rd !== m[2][4] || e !== 1'b0) begin miscompares++; $display("FAIL wait_data got %h err=%b want %h", rd, e, m[2][4]); end
   endtask
   task automatic test_partial();
      xfer(0, 1'b1, 10'h10, 32'h11223344, 4'b0101, rd, e, w, wb);
      xfer(0, 1'b0, 10'h10, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (rd !== 32'hDE22BE44 || rd !== m[0][4]) begin miscompares++; $display("FAIL partial_write got %h want de22be44", rd); end
   endtask
   task automatic test_errors();
      xfer(0, 1'b1, 10'h100, 32'hFFFFFFFF, 4'hF, rd, e, w, wb);
      vectors++; if (e !== 1'b1 || w !== 0) begin miscompares++; $display("FAIL err_range_write err=%b waits=%0d want 1/0", e, w); end
      xfer(0, 1'b0, 10'h000, 32'h0, 4'h0, rd, e, w, wb);
      vectors++; if (rd !== m[0][0] || e !== 1'b0) begin miscompares++; $display("FAIL err_no_alias got %h want %h", rd, m[0][0]); end
      xfer(0, 1'b0, 10'h002, 32'h0, 4'h0, rd, e, w, wb);
      vectors++; if (e !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL err_misaligned err=%b rdata=%h want 1/0", e, rd); end
      xfer(0, 1'b0, 10'h104, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (e !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL err_range_read err=%b rdata=%h want 1/0", e, rd); end
   endtask
   task automatic test_abort();
      logic bad = 1'b0;
      xfer(1, 1'b1, 10'h20, 32'h0BADF00D, 4'hF, rd, e, w, wb);
      idle(1);
      vectors++; if (w !== 2) begin miscompares++; $display("FAIL abort_prep waits=%0d want 2", w); end
      @(posedge clk); #1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 10'h20; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
      @(posedge clk); #1;
      penable[1] = 1'b1;
      @(negedge clk);
      if (ready[1] !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      psel[1] = 1'b0; penable[1] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if ({ready[1], err[1], rdata[1]} !== 34'h0) bad = 1'b1;
      end
      vectors++; if (bad) begin miscompares++; $display("FAIL abort_outputs response seen on aborted transfer"); end
      xfer(1, 1'b0, 10'h20, 32'h0, 4'h0, rd, e, w, wb);
      idle(1);
      vectors++; if (rd !== m[1][8] || w !== 2) begin miscompares++; $display("FAIL abort_nowrite got %h waits=%0d want %h/2", rd, w, m[1][8]); end
   endtask
   task automatic test_violation();
      logic bad = 1'b0;
      @(posedge clk); #1;
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 10'h30; pwdata[0] = ~m[0][12]; pstrb[0] = 4'hF;
      repeat (3) begin
         @(negedge clk);
         if (ready[0] !== 1'b0) bad = 1'b1;
      end
      idle(0);
      vectors++; if (bad) begin miscompares++; $display("FAIL violation_ready PREADY rose without setup"); end
      xfer(0, 1'b0, 10'h30, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (rd !== m[0][12]) begin miscompares++; $display("FAIL violation_mem got %h want %h", rd, m[0][12]); end
   endtask
   task automatic test_back_to_back();
      xfer(0, 1'b1, 10'h04, 32'hA5A5A5A5, 4'hF, rd, e, w, wb);
      xfer(0, 1'b0, 10'h04, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (rd !== 32'hA5A5A5A5 || w !== 0) begin miscompares++; $display("FAIL b2b_read got %h waits=%0d want a5a5a5a5/0", rd, w); end
      @(posedge clk); #1;
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h04; pwdata[0] = 32'h5A5A5A5A; pstrb[0] = 4'hF;
      @(posedge clk); #1;
      penable[0] = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk);
      vectors++; if ({ready[0], err[0], rdata[0]} !== 34'h0) begin miscompares++; $display("FAIL b2b_post_reset ready=%b err=%b rdata=%h want 0", ready[0], err[0], rdata[0]); end
      xfer(0, 1'b0, 10'h04, 32'h0, 4'h0, rd, e, w, wb);
      idle(0);
      vectors++; if (rd !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL b2b_reset_nowrite got %h want a5a5a5a5", rd); end
   endtask
   task automatic test_random();
      logic [9:0]  a;
      logic [31:0] wd, exp_d;
      logic [3:0]  s;
      logic        wr, exp_e;
      for (int n = 0; n < 200; n++) begin
         a = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 70) * 4) : 10'($urandom_range(0, 1023));
         wr = 1'($urandom); wd = $urandom; s = 4'($urandom);
         exp_e = exp_err(a);
         exp_d = (exp_e || wr) ? 32'h0 : m[0][a[7:2]];
         xfer(0, wr, a, wd, s, rd, e, w, wb);
         if ($urandom_range(0, 1) != 0) idle(0);
         vectors++;
         if (rd !== exp_d || e !== exp_e || w !== 0) begin
            miscompares++;
            $display("FAIL random_%0d %s a=%h rdata=%h err=%b waits=%0d want %h/%b/0", n, wr ? "wr" : "rd", a, rd, e, w, exp_d, exp_e);
         end
      end
      idle(0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
   initial begin
      test_reset();
      for (int i = 0; i < 64; i++) xfer(0, 1'b1, 10'(i * 4), $urandom, 4'hF, rd, e, w, wb);
      idle(0);
      test_basic();
      test_wait();
      test_partial();
      test_errors();
      test_abort();
      test_violation();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
